// File: rtl/abs_peak_unit.sv
`default_nettype none
// ============================================================================
// Module      : abs_peak_unit
// Description : Streaming |x| with valid/ready handshake and per-window peak
//               magnitude tracker. Define ABS_PEAK_SAT_EN to clamp -2^(W-1).
// Revision    : 1.0 - initial release
// ============================================================================
module abs_peak_unit #(
    parameter int WIDTH  = 6,
    parameter int WINDOW = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_abs,
    output logic                       out_neg,
    output logic                       out_sat,
    output logic                       peak_valid,
    output logic [WIDTH-1:0]           peak,
    output logic [$clog2(WINDOW)-1:0]  win_count
);

    localparam int                CW      = $clog2(WINDOW);
    localparam logic [CW-1:0]     c_last  = CW'(WINDOW - 1);
    localparam logic [WIDTH-1:0]  c_one   = WIDTH'(1);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_abs;
    logic             r_out_neg;
    logic             r_peak_valid;
    logic [WIDTH-1:0] r_peak;
    logic [WIDTH-1:0] r_run_max;
    logic [CW-1:0]    r_win_count;

    logic             w_accept;
    logic             w_deliver;
    logic             w_neg;
    logic [WIDTH-1:0] w_mag;
    logic [WIDTH-1:0] w_cand;
    logic             w_close;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_out_valid && out_ready;
    assign w_neg     = in_data[WIDTH-1];
    assign w_cand    = (r_run_max > r_out_abs) ? r_run_max : r_out_abs;
    assign w_close   = (r_win_count == c_last);

`ifdef ABS_PEAK_SAT_EN
    localparam logic [WIDTH-1:0] c_min = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_max = {1'b0, {(WIDTH-1){1'b1}}};

    logic r_out_sat;
    logic w_sat;

    // The only input whose negation does not fit a signed result is -2^(W-1).
    assign w_sat = (in_data == c_min);

    always_comb begin
        w_mag = in_data;
        if (w_sat)
            w_mag = c_max;
        else if (w_neg)
            w_mag = ~in_data + c_one;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_out_sat <= 1'b0;
        else if (w_accept)
            r_out_sat <= w_sat;
    end

    assign out_sat = r_out_sat;
`else
    assign w_mag   = w_neg ? (~in_data + c_one) : in_data;
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_abs    <= '0;
            r_out_neg    <= 1'b0;
            r_peak_valid <= 1'b0;
            r_peak       <= '0;
            r_run_max    <= '0;
            r_win_count  <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_abs   <= w_mag;
                r_out_neg   <= w_neg;
            end else if (w_deliver) begin
                r_out_valid <= 1'b0;
            end

            r_peak_valid <= 1'b0;
            // clear takes priority so a closing sample coinciding with it is dropped
            if (clear) begin
                r_run_max   <= '0;
                r_win_count <= '0;
            end else if (w_deliver) begin
                if (w_close) begin
                    r_peak       <= w_cand;
                    r_peak_valid <= 1'b1;
                    r_run_max    <= '0;
                    r_win_count  <= '0;
                end else begin
                    r_run_max    <= w_cand;
                    r_win_count  <= r_win_count + CW'(1);
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_abs    = r_out_abs;
    assign out_neg    = r_out_neg;
    assign peak_valid = r_peak_valid;
    assign peak       = r_peak;
    assign win_count  = r_win_count;

endmodule
`default_nettype wire
